// File: rtl/gb_csr_responder_pkg.sv
// Shared Ghostbus CSR responder definitions: window offsets, CTRL command bits, STAT field positions.
// Imported by the responder top; the FIFO sub-module is generic and needs none of it.
package gb_csr_responder_pkg;

    localparam int unsigned OFF_ID   = 0;
    localparam int unsigned OFF_CTRL = 1;
    localparam int unsigned OFF_FIFO = 2;
    localparam int unsigned OFF_STAT = 3;
    localparam int unsigned OFF_REG0 = 4;

    localparam int unsigned CTRL_FLUSH   = 0;
    localparam int unsigned CTRL_CLR_OVF = 1;
    localparam int unsigned CTRL_CLR_UDF = 2;

    localparam int unsigned STAT_CNT_W = 16;
    localparam int unsigned STAT_EMPTY = 16;
    localparam int unsigned STAT_FULL  = 17;
    localparam int unsigned STAT_OVF   = 24;
    localparam int unsigned STAT_UDF   = 25;

endpackage

// File: rtl/gb_sync_fifo.sv
// Circular capture FIFO, 2**AW x DW; head is combinational so a pop's data can be registered by the caller.
// No backpressure: overfull pushes and empty pops are reported as single-cycle drop/underflow pulses.
module gb_sync_fifo #(
    parameter int AW = 3,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [DW-1:0] head_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          push_drop_o,
    output logic          pop_empty_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_ok;
    logic          push_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A pop on a full FIFO frees the slot the simultaneous push needs; flush drops the push silently.
    assign pop_ok      = pop_i && !empty_o;
    assign push_ok     = push_i && !flush_i && (!full_o || pop_ok);
    assign push_drop_o = push_i && !flush_i && full_o && !pop_ok;
    assign pop_empty_o = pop_i && empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/gb_csr_responder.sv
// Ghostbus leaf responder: ID, CTRL/STAT, NREG config registers and a host-drained capture FIFO.
// Reads return registered data exactly 1 cycle after the strobe, zero otherwise; no backpressure.
module gb_csr_responder
    import gb_csr_responder_pkg::*;
#(
    parameter int               GB_AW    = 24,
    parameter int               GB_DW    = 32,
    parameter int unsigned      BASE     = 0,
    parameter int               LOCAL_AW = 4,
    parameter int               NREG     = 8,
    parameter int               FIFO_AW  = 3,
    parameter logic [GB_DW-1:0] ID       = 'h47425253
) (
    input  logic                    gb_clk,
    input  logic                    rst,
    input  logic [GB_AW-1:0]        gb_addr,
    input  logic [GB_DW-1:0]        gb_wdata,
    input  logic                    gb_wen,
    input  logic                    gb_rstb,
    output logic [GB_DW-1:0]        gb_rdata,
    output logic [NREG*GB_DW-1:0]   regs_flat,
    output logic [NREG-1:0]         reg_wr_stb,
    input  logic                    fifo_push,
    input  logic [GB_DW-1:0]        fifo_din,
    output logic                    fifo_full,
    output logic                    fifo_empty
);

    localparam logic [GB_AW-1:0] BASE_A = GB_AW'(BASE);

    logic                hit;
    logic [LOCAL_AW-1:0] off;
    logic                rd;
    logic                wr;

    logic [GB_DW-1:0]    regs_q [NREG];
    logic [GB_DW-1:0]    regs_d [NREG];
    logic [NREG-1:0]     stb_q, stb_d;
    logic [GB_DW-1:0]    rdata_q, rdata_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    logic                fifo_pop;
    logic                fifo_flush;
    logic [GB_DW-1:0]    fifo_head;
    logic [FIFO_AW:0]    fifo_count;
    logic                fifo_push_drop;
    logic                fifo_pop_empty;
    logic [GB_DW-1:0]    stat_w;

    assign hit = (gb_addr[GB_AW-1:LOCAL_AW] == BASE_A[GB_AW-1:LOCAL_AW]);
    assign off = gb_addr[LOCAL_AW-1:0];
    assign rd  = gb_rstb && hit;
    assign wr  = gb_wen && hit;

    assign fifo_pop   = rd && (off == LOCAL_AW'(OFF_FIFO));
    assign fifo_flush = wr && (off == LOCAL_AW'(OFF_CTRL)) && gb_wdata[CTRL_FLUSH];

    gb_sync_fifo #(
        .AW (FIFO_AW),
        .DW (GB_DW)
    ) u_fifo (
        .clk_i       (gb_clk),
        .rst_i       (rst),
        .push_i      (fifo_push),
        .din_i       (fifo_din),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .push_drop_o (fifo_push_drop),
        .pop_empty_o (fifo_pop_empty)
    );

    always_comb begin
        stat_w                 = '0;
        stat_w[FIFO_AW:0]      = fifo_count;
        stat_w[STAT_EMPTY]     = fifo_empty;
        stat_w[STAT_FULL]      = fifo_full;
        stat_w[STAT_OVF]       = ovf_q;
        stat_w[STAT_UDF]       = udf_q;
    end

    // Sticky set takes priority over a same-cycle clear so no event is lost.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (wr && (off == LOCAL_AW'(OFF_CTRL))) begin
            if (gb_wdata[CTRL_CLR_OVF]) ovf_d = 1'b0;
            if (gb_wdata[CTRL_CLR_UDF]) udf_d = 1'b0;
        end
        if (fifo_push_drop) ovf_d = 1'b1;
        if (fifo_pop_empty) udf_d = 1'b1;
    end

    always_comb begin
        regs_d = regs_q;
        stb_d  = '0;
        for (int k = 0; k < NREG; k++) begin
            if (wr && (off == LOCAL_AW'(OFF_REG0 + k))) begin
                regs_d[k] = gb_wdata;
                stb_d[k]  = 1'b1;
            end
        end
    end

    // Read mux sees pre-write state, so a same-cycle write+read returns the old value.
    always_comb begin
        rdata_d = '0;
        if (rd) begin
            if (off == LOCAL_AW'(OFF_ID)) begin
                rdata_d = ID;
            end else if (off == LOCAL_AW'(OFF_FIFO)) begin
                rdata_d = fifo_empty ? '0 : fifo_head;
            end else if (off == LOCAL_AW'(OFF_STAT)) begin
                rdata_d = stat_w;
            end else begin
                for (int k = 0; k < NREG; k++) begin
                    if (off == LOCAL_AW'(OFF_REG0 + k)) rdata_d = regs_q[k];
                end
            end
        end
    end

    always_ff @(posedge gb_clk) begin
        if (rst) begin
            regs_q  <= '{default: '0};
            stb_q   <= '0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            stb_q   <= stb_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign gb_rdata   = rdata_q;
    assign reg_wr_stb = stb_q;

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat[g*GB_DW +: GB_DW] = regs_q[g];
    end

endmodule

// File: tb/tb_gb_csr_responder.sv
// Directed bench for gb_csr_responder: queue-based reference model checked every cycle, plus literal read expectations.
module tb_gb_csr_responder;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int DEPTH = 8;
    localparam logic [31:0] ID = 32'h47425253;

    logic              gb_clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     gb_addr;
    logic [DW-1:0]     gb_wdata;
    logic              gb_wen;
    logic              gb_rstb;
    logic [DW-1:0]     gb_rdata;
    logic [NR*DW-1:0]  regs_flat;
    logic [NR-1:0]     reg_wr_stb;
    logic              fifo_push;
    logic [DW-1:0]     fifo_din;
    logic              fifo_full;
    logic              fifo_empty;

    int errors = 0;
    int checks = 0;

    gb_csr_responder dut (
        .gb_clk     (gb_clk),
        .rst        (rst),
        .gb_addr    (gb_addr),
        .gb_wdata   (gb_wdata),
        .gb_wen     (gb_wen),
        .gb_rstb    (gb_rstb),
        .gb_rdata   (gb_rdata),
        .regs_flat  (regs_flat),
        .reg_wr_stb (reg_wr_stb),
        .fifo_push  (fifo_push),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    always #5 gb_clk = ~gb_clk;

    task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [NR];
    logic [31:0] m_q [$];
    logic        m_ovf, m_udf;
    logic [31:0] m_rdata;
    logic [NR-1:0] m_stb;
    bit          m_valid = 0;

    logic        mh, mrd, mwr, mpop, mflush, mdidpop;
    int          moff;
    logic [31:0] mnext;

    function automatic logic [31:0] m_stat();
        logic [31:0] s;
        s = 32'(m_q.size());
        if (m_q.size() == 0)     s = s | 32'h0001_0000;
        if (m_q.size() == DEPTH) s = s | 32'h0002_0000;
        if (m_ovf)               s = s | 32'h0100_0000;
        if (m_udf)               s = s | 32'h0200_0000;
        return s;
    endfunction

    always @(posedge gb_clk) begin
        if (rst) begin
            m_valid = 1;
            m_rdata = 0;
            m_stb   = 0;
            m_ovf   = 0;
            m_udf   = 0;
            m_q.delete();
            for (int k = 0; k < NR; k++) m_regs[k] = 0;
        end else if (m_valid) begin
            mh   = (gb_addr >> 4) == 0;
            moff = int'(gb_addr % 16);
            mrd  = gb_rstb && mh;
            mwr  = gb_wen && mh;
            mnext = 0;
            if (mrd) begin
                if (moff == 0) mnext = ID;
                else if (moff == 2) mnext = (m_q.size() > 0) ? m_q[0] : 32'h0;
                else if (moff == 3) mnext = m_stat();
                else if (moff >= 4 && moff < 4 + NR) mnext = m_regs[moff-4];
            end
            mpop    = mrd && moff == 2;
            mflush  = mwr && moff == 1 && gb_wdata[0];
            mdidpop = mpop && m_q.size() > 0;
            if (mwr && moff == 1 && gb_wdata[1]) m_ovf = 0;
            if (mwr && moff == 1 && gb_wdata[2]) m_udf = 0;
            if (mpop && m_q.size() == 0) m_udf = 1;
            if (fifo_push && !mflush && m_q.size() == DEPTH && !mdidpop) m_ovf = 1;
            if (mdidpop) void'(m_q.pop_front());
            if (mflush) m_q.delete();
            else if (fifo_push && (m_q.size() < DEPTH)) m_q.push_back(fifo_din);
            m_stb = 0;
            if (mwr && moff >= 4 && moff < 4 + NR) begin
                m_regs[moff-4] = gb_wdata;
                m_stb[moff-4]  = 1'b1;
            end
            m_rdata = mnext;
        end
    end

    logic [NR*DW-1:0] m_flat;
    always @(negedge gb_clk) begin
        if (m_valid) begin
            for (int k = 0; k < NR; k++) m_flat[k*DW +: DW] = m_regs[k];
            check("rdata",  gb_rdata,   m_rdata);
            check("regs",   regs_flat,  m_flat);
            check("stb",    reg_wr_stb, m_stb);
            check("full",   fifo_full,  m_q.size() == DEPTH);
            check("empty",  fifo_empty, m_q.size() == 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        gb_wen = 0; gb_rstb = 0; fifo_push = 0;
    endtask

    task automatic drive(input logic wen, input logic rstb, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic push, input logic [31:0] din);
        @(negedge gb_clk);
        gb_wen = wen; gb_rstb = rstb; gb_addr = a; gb_wdata = d;
        fifo_push = push; fifo_din = din;
        @(negedge gb_clk);
        idle();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        drive(1, 0, a, d, 0, 0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
        drive(0, 1, a, 0, 0, 0);
        check(name, gb_rdata, exp);
    endtask

    task automatic push(input logic [31:0] d);
        drive(0, 0, 0, 0, 1, d);
    endtask

    initial begin
        rst = 1; gb_addr = 0; gb_wdata = 0; fifo_din = 0;
        idle();
        repeat (2) @(negedge gb_clk);
        check("rst_rdata", gb_rdata, 0);
        check("rst_regs",  regs_flat, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full",  fifo_full, 0);
        rst = 0;

        rd(0, ID,            "rd_id");
        rd(3, 32'h0001_0000, "rd_stat_reset");
        rd(4, 0,             "rd_reg0_reset");
        rd(9, 0,             "rd_reg5_reset");

        wr(6, 32'hDEADBEEF);
        check("reg2_val", regs_flat[95:64], 32'hDEADBEEF);
        check("reg2_stb", reg_wr_stb, 8'b0000_0100);
        @(negedge gb_clk);
        check("reg2_stb_off", reg_wr_stb, 0);
        rd(6, 32'hDEADBEEF, "rd_reg2");
        wr(16, 32'h1234_5678);
        rd(16, 0,            "rd_miss");
        rd(6, 32'hDEADBEEF, "rd_reg2_after_miss");

        for (int i = 1; i <= 10; i++) begin
            @(negedge gb_clk);
            fifo_push = 1; fifo_din = i;
        end
        @(negedge gb_clk);
        idle();
        rd(3, 32'h0102_0008, "stat_full_ovf");
        for (int i = 1; i <= 8; i++) rd(2, i, "pop_data");
        rd(2, 0,             "pop_underflow");
        rd(3, 32'h0301_0000, "stat_both_sticky");

        wr(1, 32'h6);
        rd(3, 32'h0001_0000, "stat_cleared");
        for (int i = 0; i < 3; i++) push(32'hA0 + i);
        wr(1, 32'h1);
        rd(3, 32'h0001_0000, "stat_flushed");

        for (int i = 0; i < 8; i++) push(32'h100 + i);
        drive(0, 1, 2, 0, 1, 32'h200);
        check("full_pushpop_head", gb_rdata, 32'h100);
        rd(3, 32'h0002_0008, "stat_full_no_ovf");
        drive(1, 0, 1, 32'h2, 1, 32'h201);
        rd(3, 32'h0102_0008, "stat_ovf_set_wins");
        drive(1, 0, 1, 32'h3, 1, 32'h202);
        rd(3, 32'h0001_0000, "stat_flush_beats_push");
        drive(0, 1, 2, 0, 1, 32'h300);
        check("empty_pushpop_rd", gb_rdata, 0);
        rd(3, 32'h0200_0001, "stat_empty_pushpop");
        rd(2, 32'h300,       "pop_after_empty_push");

        push(32'h55);
        @(negedge gb_clk);
        rst = 1; gb_addr = 6; gb_rstb = 1;
        @(negedge gb_clk);
        rst = 0; idle();
        check("rst_abort_rdata", gb_rdata, 0);
        check("rst_abort_regs",  regs_flat, 0);
        check("rst_abort_empty", fifo_empty, 1);
        rd(3, 32'h0001_0000, "stat_after_rst");

        wr(4, 32'hA5A5_A5A5);
        drive(1, 1, 4, 32'h5A5A_5A5A, 0, 0);
        check("wr_rd_same_old", gb_rdata, 32'hA5A5_A5A5);
        rd(4, 32'h5A5A_5A5A, "wr_rd_same_new");

        repeat (2) @(negedge gb_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
